mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 256: byte depth of the attached ram; legal addresses are 0..DEPTH-1.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have, per requester x in {0,1}, input ports m<x>_req (1), m<x>_we (1), m<x>_size (2: 0=byte, 1=half, 2=word, 3=reserved), m<x>_addr (32) and m<x>_wdata (32).
REQ-005 SHALL have, per requester x, output ports m<x>_gnt (1, request accepted), m<x>_rvalid (1, response valid), m<x>_rdata (32) and m<x>_err (1, response is an error); and input port m<x>_rready (1).
REQ-006 SHALL have output ports ram_en (1), ram_we (1), ram_byte_sel (2), ram_addr (32) and ram_wdata (32); and input port ram_rdata (32), which is the combinational port-A read of {addr+3..addr}.

Function
REQ-007 SHALL implement the FSM states IDLE, ACCESS and RESP; exactly one transaction SHALL be in flight at a time.
REQ-008 IDLE: if either req is high, the block SHALL select a winner, assert the winner's gnt combinationally in that cycle only, latch the winner's we/size/addr/wdata and owner id, and go to ACCESS.
REQ-009 Arbitration SHALL be round-robin: if both reqs are high, the requester not granted last wins; after reset, m0 wins.
REQ-010 A sole requester SHALL be granted regardless of pointer; the pointer SHALL update to the winner on every grant.
REQ-011 Requesters SHALL hold req and fields stable until gnt; a req dropped before gnt SHALL be ignored without error.
REQ-012 The error check SHALL be evaluated on the latched request: err = (size==3) | (size==1 & addr[0]) | (size==2 & addr[1:0]!=0) | (addr + bytes - 1 >= DEPTH), where bytes=1/2/4.
REQ-013 ACCESS, no error: the block SHALL assert ram_en=1, ram_we=latched we, ram_byte_sel=size, ram_addr=addr and ram_wdata=wdata for exactly one cycle; the write commits at that edge.
REQ-014 ACCESS, no error, read: the block SHALL register ram_rdata masked to size and zero-extended (byte [7:0], half [15:0], word [31:0]) into the owner's rdata.
REQ-015 ACCESS with error: the block SHALL keep ram_en=0 and ram_we=0, set the owner's err=1 and rdata=0, and the RAM SHALL be unchanged.
REQ-016 ACCESS SHALL always last one cycle and then go to RESP.
REQ-017 RESP: the owner's rvalid SHALL be 1, with rdata/err stable; writes SHALL return rdata=0, err=0 on success. The non-owner's rvalid SHALL be 0.
REQ-018 RESP SHALL stay until the owner's rready is high, then clear rvalid and go to IDLE at that edge. A new grant is possible in the next cycle (min. 3 cycles per transaction).
REQ-019 Outside ACCESS, ram_en and ram_we SHALL be 0, and ram_addr, ram_wdata and ram_byte_sel SHALL hold their latched values.
REQ-020 A req from the other requester during ACCESS/RESP SHALL not be granted until IDLE.

Reset
REQ-021 rst_n low SHALL immediately force state=IDLE, the pointer to favour m0, all gnt/rvalid/err=0, rdata=0, ram_en=0, ram_we=0, ram_byte_sel=0, ram_addr=0 and ram_wdata=0.
REQ-022 Reset asserted during ACCESS SHALL suppress the pending write if it precedes the edge; a transaction aborted by reset SHALL produce no response.

Verification
REQ-023 A bench SHALL cover: m0 word write 0xDEADBEEF at 0x10, then m0 byte read at 0x11 -> rvalid with rdata=0x000000BE, err=0.
REQ-024 A bench SHALL cover: m0 and m1 reqs both held continuously from reset -> grants in the order m0, m1, m0, m1; each rvalid goes only to its owner.
REQ-025 A bench SHALL cover: m1 half write at 0x21 -> err=1, ram_en never high, and a word read at 0x20 returns the prior contents.
REQ-026 A bench SHALL cover: m0 word read at DEPTH-2 (254) -> err=1 and rdata=0; a word read at 252 -> err=0.
REQ-027 A bench SHALL cover: rready held low 5 cycles in RESP -> rvalid, rdata and err stable for all 5 cycles, and no new grant is issued in those cycles.
REQ-028 A bench SHALL cover: rst_n pulsed low mid-RESP -> rvalid drops asynchronously, and the first grant after reset goes to m0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - two-requester memory arbiter bus bundle
interface mem_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [1:0]  m0_size;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m0_err;
  logic        m0_rready;

  logic        m1_req;
  logic        m1_we;
  logic [1:0]  m1_size;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;
  logic        m1_err;
  logic        m1_rready;

  logic        ram_en;
  logic        ram_we;
  logic [1:0]  ram_byte_sel;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  // arbiter side
  modport slave (
    input  m0_req, m0_we, m0_size, m0_addr, m0_wdata, m0_rready,
    output m0_gnt, m0_rvalid, m0_rdata, m0_err,
    input  m1_req, m1_we, m1_size, m1_addr, m1_wdata, m1_rready,
    output m1_gnt, m1_rvalid, m1_rdata, m1_err,
    output ram_en, ram_we, ram_byte_sel, ram_addr, ram_wdata,
    input  ram_rdata
  );

  // requesters and ram side
  modport master (
    output m0_req, m0_we, m0_size, m0_addr, m0_wdata, m0_rready,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
    output m1_req, m1_we, m1_size, m1_addr, m1_wdata, m1_rready,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
    input  ram_en, ram_we, ram_byte_sel, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin two-master arbiter onto a single byte ram port
module mem_arbiter #(
  parameter int unsigned DEPTH = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  state_t      state_nx;

  logic        last_win;   // 1 = m1 won the most recent grant
  logic        own;
  logic        l_we;
  logic [1:0]  l_size;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;

  logic        any_req;
  logic        win1;
  logic        owner_rready;
  logic [2:0]  bytes;
  logic [32:0] last_byte;
  logic        err_c;
  logic [31:0] rd_mask;
  logic [31:0] resp_data;

  logic        r0_valid;
  logic        r0_err;
  logic [31:0] r0_data;
  logic        r1_valid;
  logic        r1_err;
  logic [31:0] r1_data;

  // m1 wins when alone, or when both request and m0 won last
  assign any_req      = bus.m0_req | bus.m1_req;
  assign win1         = bus.m1_req & (~bus.m0_req | ~last_win);
  assign owner_rready = own ? bus.m1_rready : bus.m0_rready;

  assign bus.m0_gnt = rst_n & (state == IDLE) & bus.m0_req & ~win1;
  assign bus.m1_gnt = rst_n & (state == IDLE) & win1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = ACCESS;
      ACCESS:  state_nx = RESP;
      RESP:    if (owner_rready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_win <= 1'b1;
      own      <= 1'b0;
      l_we     <= 1'b0;
      l_size   <= 2'd0;
      l_addr   <= 32'd0;
      l_wdata  <= 32'd0;
    end else if (state == IDLE && any_req) begin
      last_win <= win1;
      own      <= win1;
      l_we     <= win1 ? bus.m1_we    : bus.m0_we;
      l_size   <= win1 ? bus.m1_size  : bus.m0_size;
      l_addr   <= win1 ? bus.m1_addr  : bus.m0_addr;
      l_wdata  <= win1 ? bus.m1_wdata : bus.m0_wdata;
    end
  end

  always_comb begin
    bytes = 3'd1;
    case (l_size)
      2'd1:    bytes = 3'd2;
      2'd2:    bytes = 3'd4;
      default: bytes = 3'd1;
    endcase
  end

  // 33-bit sum so addresses near 2^32 cannot wrap back into range
  assign last_byte = {1'b0, l_addr} + {30'd0, bytes} - 33'd1;
  assign err_c = (l_size == 2'd3)
               | ((l_size == 2'd1) & l_addr[0])
               | ((l_size == 2'd2) & (l_addr[1:0] != 2'b00))
               | (last_byte >= 33'(DEPTH));

  always_comb begin
    rd_mask = bus.ram_rdata;
    case (l_size)
      2'd0:    rd_mask = {24'd0, bus.ram_rdata[7:0]};
      2'd1:    rd_mask = {16'd0, bus.ram_rdata[15:0]};
      default: rd_mask = bus.ram_rdata;
    endcase
  end

  assign resp_data = (l_we | err_c) ? 32'd0 : rd_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0_valid <= 1'b0;
      r0_err   <= 1'b0;
      r0_data  <= 32'd0;
      r1_valid <= 1'b0;
      r1_err   <= 1'b0;
      r1_data  <= 32'd0;
    end else if (state == ACCESS) begin
      if (own) begin
        r1_valid <= 1'b1;
        r1_err   <= err_c;
        r1_data  <= resp_data;
      end else begin
        r0_valid <= 1'b1;
        r0_err   <= err_c;
        r0_data  <= resp_data;
      end
    end else if (state == RESP && owner_rready) begin
      if (own) begin
        r1_valid <= 1'b0;
      end else begin
        r0_valid <= 1'b0;
      end
    end
  end

  assign bus.m0_rvalid = r0_valid;
  assign bus.m0_err    = r0_err;
  assign bus.m0_rdata  = r0_data;
  assign bus.m1_rvalid = r1_valid;
  assign bus.m1_err    = r1_err;
  assign bus.m1_rdata  = r1_data;

  // address/data/size simply follow the latched request; only the strobes are gated
  assign bus.ram_en       = (state == ACCESS) & ~err_c;
  assign bus.ram_we       = bus.ram_en & l_we;
  assign bus.ram_byte_sel = l_size;
  assign bus.ram_addr     = l_addr;
  assign bus.ram_wdata    = l_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mem_arbiter_if bus ();

  mem_arbiter #(.DEPTH(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // byte ram: combinational read of {a+3..a}, write on the rising edge
  logic [7:0] mem [0:255];
  logic [7:0] ra;
  assign ra = bus.ram_addr[7:0];
  assign bus.ram_rdata = {mem[8'(ra + 8'd3)], mem[8'(ra + 8'd2)], mem[8'(ra + 8'd1)], mem[ra]};

  always @(posedge clk) begin
    if (bus.ram_en && bus.ram_we) begin
      mem[ra] <= bus.ram_wdata[7:0];
      if (bus.ram_byte_sel != 2'd0) mem[8'(ra + 8'd1)] <= bus.ram_wdata[15:8];
      if (bus.ram_byte_sel == 2'd2) begin
        mem[8'(ra + 8'd2)] <= bus.ram_wdata[23:16];
        mem[8'(ra + 8'd3)] <= bus.ram_wdata[31:24];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit x, input bit req, input bit we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (x) begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_size = size;
      bus.m1_addr = addr; bus.m1_wdata = wdata;
    end else begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_size = size;
      bus.m0_addr = addr; bus.m0_wdata = wdata;
    end
  endtask

  // starts at posedge+1 in IDLE; ends at posedge+1 back in IDLE
  task automatic txn(input string tag, input bit x, input bit we, input logic [1:0] size,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input bit exp_err);
    bit got;
    got = 1'b0;
    drive(x, 1'b1, we, size, addr, wdata);
    if (x) bus.m1_rready = 1'b1; else bus.m0_rready = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      #1;
      if ((x ? bus.m1_gnt : bus.m0_gnt) === 1'b1) got = 1'b1;
      @(posedge clk); #1;
    end
    drive(x, 1'b0, we, size, addr, wdata);
    if (!got) begin
      checks++; errors++;
      $error("FAIL %s_gnt_timeout: observed no grant expected grant within 20 cycles", tag);
    end else begin
      check({tag, "_ram_en"}, {31'd0, bus.ram_en}, {31'd0, !exp_err});
      if (!exp_err) begin
        check({tag, "_ram_we"}, {31'd0, bus.ram_we}, {31'd0, we});
        check({tag, "_ram_addr"}, bus.ram_addr, addr);
        if (we) check({tag, "_ram_wdata"}, bus.ram_wdata, wdata);
      end
      @(posedge clk); #1;
      check({tag, "_rvalid"}, {31'd0, x ? bus.m1_rvalid : bus.m0_rvalid}, 32'd1);
      check({tag, "_other_rvalid"}, {31'd0, x ? bus.m0_rvalid : bus.m1_rvalid}, 32'd0);
      check({tag, "_rdata"}, x ? bus.m1_rdata : bus.m0_rdata, exp_rdata);
      check({tag, "_err"}, {31'd0, x ? bus.m1_err : bus.m0_err}, {31'd0, exp_err});
      @(posedge clk); #1;
      check({tag, "_rvalid_clr"}, {31'd0, x ? bus.m1_rvalid : bus.m0_rvalid}, 32'd0);
    end
  endtask

  initial begin
    int g[$];
    int owner;
    checks = 0;
    errors = 0;
    owner  = -1;
    rst_n  = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    bus.m0_rready = 1'b1;
    bus.m1_rready = 1'b1;

    #12;
    check("rst_m0_gnt", {31'd0, bus.m0_gnt}, 32'd0);
    check("rst_m1_gnt", {31'd0, bus.m1_gnt}, 32'd0);
    check("rst_m0_rvalid", {31'd0, bus.m0_rvalid}, 32'd0);
    check("rst_m1_rvalid", {31'd0, bus.m1_rvalid}, 32'd0);
    check("rst_m0_err", {31'd0, bus.m0_err}, 32'd0);
    check("rst_m0_rdata", bus.m0_rdata, 32'd0);
    check("rst_m1_rdata", bus.m1_rdata, 32'd0);
    check("rst_ram_en", {31'd0, bus.ram_en}, 32'd0);
    check("rst_ram_we", {31'd0, bus.ram_we}, 32'd0);
    check("rst_ram_sel", {30'd0, bus.ram_byte_sel}, 32'd0);
    check("rst_ram_addr", bus.ram_addr, 32'd0);
    check("rst_ram_wdata", bus.ram_wdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    txn("wr_w10", 1'b0, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
    check("idle_ram_en", {31'd0, bus.ram_en}, 32'd0);
    check("idle_ram_addr_hold", bus.ram_addr, 32'h10);
    txn("rd_b11", 1'b0, 1'b0, 2'd0, 32'h11, 32'd0, 32'h000000BE, 1'b0);
    txn("rd_h12", 1'b0, 1'b0, 2'd1, 32'h12, 32'd0, 32'h0000DEAD, 1'b0);
    txn("wr_w20", 1'b1, 1'b1, 2'd2, 32'h20, 32'hCAFEF00D, 32'd0, 1'b0);
    txn("wr_h21", 1'b1, 1'b1, 2'd1, 32'h21, 32'h00001234, 32'd0, 1'b1);
    txn("rd_w20", 1'b1, 1'b0, 2'd2, 32'h20, 32'd0, 32'hCAFEF00D, 1'b0);
    txn("rd_w254", 1'b0, 1'b0, 2'd2, 32'd254, 32'd0, 32'd0, 1'b1);
    txn("wr_w252", 1'b0, 1'b1, 2'd2, 32'd252, 32'h11223344, 32'd0, 1'b0);
    txn("rd_w252", 1'b0, 1'b0, 2'd2, 32'd252, 32'd0, 32'h11223344, 1'b0);
    txn("rd_b255", 1'b0, 1'b0, 2'd0, 32'd255, 32'd0, 32'h00000011, 1'b0);
    txn("rd_h254", 1'b0, 1'b0, 2'd1, 32'd254, 32'd0, 32'h00001122, 1'b0);
    txn("rd_rsvd", 1'b0, 1'b0, 2'd3, 32'h10, 32'd0, 32'd0, 1'b1);
    txn("rd_w12_mis", 1'b0, 1'b0, 2'd2, 32'h12, 32'd0, 32'd0, 1'b1);
    txn("rd_b256", 1'b1, 1'b0, 2'd0, 32'd256, 32'd0, 32'd0, 1'b1);

    // response stall: rready low for 5 RESP cycles while m1 waits
    drive(1'b0, 1'b1, 1'b0, 2'd2, 32'h10, 32'd0);
    bus.m0_rready = 1'b0;
    #1;
    check("stall_m0_gnt", {31'd0, bus.m0_gnt}, 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 2'd2, 32'h10, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 2'd2, 32'h20, 32'd0);
    #1;
    check("stall_access_m1_gnt", {31'd0, bus.m1_gnt}, 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("stall_rvalid", {31'd0, bus.m0_rvalid}, 32'd1);
      check("stall_rdata", bus.m0_rdata, 32'hDEADBEEF);
      check("stall_err", {31'd0, bus.m0_err}, 32'd0);
      check("stall_m1_gnt", {31'd0, bus.m1_gnt}, 32'd0);
      @(posedge clk); #1;
    end
    bus.m0_rready = 1'b1;
    #1;
    check("stall_rel_m1_gnt", {31'd0, bus.m1_gnt}, 32'd0);
    @(posedge clk); #1;
    check("stall_m0_rvalid_clr", {31'd0, bus.m0_rvalid}, 32'd0);
    check("stall_m1_gnt_idle", {31'd0, bus.m1_gnt}, 32'd1);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 2'd2, 32'h20, 32'd0);
    @(posedge clk); #1;
    check("stall_m1_rvalid", {31'd0, bus.m1_rvalid}, 32'd1);
    check("stall_m1_rdata", bus.m1_rdata, 32'hCAFEF00D);
    @(posedge clk); #1;

    // round robin with both requests held from reset
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 2'd2, 32'h10, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 2'd2, 32'h20, 32'd0);
    #1;
    check("rr_rst_m0_gnt", {31'd0, bus.m0_gnt}, 32'd0);
    check("rr_rst_m1_gnt", {31'd0, bus.m1_gnt}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 40 && g.size() < 4; c++) begin
      #1;
      if (bus.m0_gnt) begin g.push_back(0); owner = 0; end
      if (bus.m1_gnt) begin g.push_back(1); owner = 1; end
      if (bus.m0_rvalid || bus.m1_rvalid) begin
        check("rr_rvalid_owner", {30'd0, bus.m1_rvalid, bus.m0_rvalid},
              (owner == 1) ? 32'd2 : 32'd1);
        check("rr_rdata", (owner == 1) ? bus.m1_rdata : bus.m0_rdata,
              (owner == 1) ? 32'hCAFEF00D : 32'hDEADBEEF);
      end
      @(posedge clk); #1;
    end
    drive(1'b0, 1'b0, 1'b0, 2'd2, 32'h10, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 2'd2, 32'h20, 32'd0);
    check("rr_grant_count", g.size(), 32'd4);
    for (int i = 0; i < g.size(); i++) check("rr_order", g[i], i % 2);
    @(posedge clk); #1;
    check("rr_last_m1_rvalid", {31'd0, bus.m1_rvalid}, 32'd1);
    check("rr_last_m0_rvalid", {31'd0, bus.m0_rvalid}, 32'd0);
    @(posedge clk); #1;

    // reset mid-RESP: response vanishes at once, m0 wins first afterwards
    drive(1'b0, 1'b1, 1'b0, 2'd2, 32'h10, 32'd0);
    bus.m0_rready = 1'b0;
    #1;
    check("rmid_gnt", {31'd0, bus.m0_gnt}, 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 2'd2, 32'h10, 32'd0);
    @(posedge clk); #1;
    check("rmid_rvalid_pre", {31'd0, bus.m0_rvalid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rmid_rvalid_async", {31'd0, bus.m0_rvalid}, 32'd0);
    check("rmid_rdata_async", bus.m0_rdata, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 2'd2, 32'h10, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 2'd2, 32'h20, 32'd0);
    #1;
    check("rmid_rst_m0_gnt", {31'd0, bus.m0_gnt}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("rmid_first_m0_gnt", {31'd0, bus.m0_gnt}, 32'd1);
    check("rmid_first_m1_gnt", {31'd0, bus.m1_gnt}, 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 2'd2, 32'h10, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 2'd2, 32'h20, 32'd0);
    bus.m0_rready = 1'b1;
    @(posedge clk); #1;
    check("rmid_resp_rvalid", {31'd0, bus.m0_rvalid}, 32'd1);
    check("rmid_resp_rdata", bus.m0_rdata, 32'hDEADBEEF);
    check("rmid_m1_rvalid", {31'd0, bus.m1_rvalid}, 32'd0);
    @(posedge clk); #1;
    check("rmid_rvalid_clr", {31'd0, bus.m0_rvalid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
